// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-address generator.
//  - fetch_state_t : BOOT / RUN / HALTED / TRAP encodings driven on STATE_PCF
//  - trap_cause_t  : trap cause codes driven on TRAP_CAUSE_PCF
//  - DEFAULT_RESET_VECTOR : default first fetch address
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_TRAP   = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_RANGE      = 2'b10
  } trap_cause_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_check.sv
// Combinational legality check for a candidate next-PC.
// Ports:
//  candidate [31:0] in  : proposed fetch byte address
//  carry            in  : carry out of the address computation (always out of range)
//  legal            out : candidate may be fetched
//  cause     [1:0]  out : trap cause when illegal (misaligned takes precedence)
module fetch_target_check
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic [31:0] candidate,
  input  logic        carry,
  output logic        legal,
  output logic [1:0]  cause
);

  // 34-bit compare so the carry and an IMEM_WORDS*4 of 2^32 both fit.
  localparam logic [33:0] LIMIT = 34'(IMEM_WORDS) * 34'd4;

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (candidate[1:0] != 2'b00);
  assign out_of_range = ({1'b0, carry, candidate} >= LIMIT);

  always_comb begin
    legal = 1'b1;
    cause = CAUSE_NONE;
    if (misaligned) begin
      legal = 1'b0;
      cause = CAUSE_MISALIGNED;
    end else if (out_of_range) begin
      legal = 1'b0;
      cause = CAUSE_RANGE;
    end
  end

endmodule

// File: rtl/program_counter_fetch.sv
// Fetch-address generator feeding the instruction memory.
// Holds the architectural PC (driven on A_IM), advances by 4, stalls, redirects
// to branch/jump targets, traps on illegal fetch addresses and supports halt/resume.
// Ports:
//  CLK, RST_N (sync, active-low)
//  STALL_PCF, BR_TAKEN_PCF, BR_TARGET_PCF[31:0], HALT_PCF, RESUME_PCF : requests
//  A_IM[31:0]         : current PC / fetch address
//  PC_PLUS4_PCF[31:0] : A_IM + 4 (combinational, link value)
//  VALID_PCF          : A_IM holds an instruction to execute
//  STATE_PCF[1:0]     : BOOT / RUN / HALTED / TRAP
//  TRAP_CAUSE_PCF[1:0], TRAP_PC_PCF[31:0] : captured trap information
//  RETIRED_CNT_PCF[31:0] : PC updates performed in RUN
module program_counter_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned IMEM_WORDS   = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL_PCF,
  input  logic        BR_TAKEN_PCF,
  input  logic [31:0] BR_TARGET_PCF,
  input  logic        HALT_PCF,
  input  logic        RESUME_PCF,
  output logic [31:0] A_IM,
  output logic [31:0] PC_PLUS4_PCF,
  output logic        VALID_PCF,
  output logic [1:0]  STATE_PCF,
  output logic [1:0]  TRAP_CAUSE_PCF,
  output logic [31:0] TRAP_PC_PCF,
  output logic [31:0] RETIRED_CNT_PCF
);

  fetch_state_t state;
  trap_cause_t  trap_cause;
  logic [31:0]  pc;
  logic         valid;
  logic [31:0]  trap_pc;
  logic [31:0]  retired_cnt;

  logic [32:0]  seq_sum;
  logic         seq_legal;
  logic [1:0]   seq_cause;
  logic         br_legal;
  logic [1:0]   br_cause;

  logic         advance;
  logic         use_br;
  logic [31:0]  cand;
  logic         cand_legal;
  logic [1:0]   cand_cause;

  assign seq_sum = {1'b0, pc} + 33'd4;

  fetch_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_seq_check (
    .candidate (seq_sum[31:0]),
    .carry     (seq_sum[32]),
    .legal     (seq_legal),
    .cause     (seq_cause)
  );

  fetch_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_br_check (
    .candidate (BR_TARGET_PCF),
    .carry     (1'b0),
    .legal     (br_legal),
    .cause     (br_cause)
  );

  // Pick the candidate by priority; HALT in RUN suppresses any advance,
  // a redirect is taken even when STALL is asserted.
  always_comb begin
    advance = 1'b0;
    use_br  = 1'b0;
    case (state)
      ST_RUN: begin
        if (!HALT_PCF) begin
          if (BR_TAKEN_PCF) begin
            advance = 1'b1;
            use_br  = 1'b1;
          end else if (!STALL_PCF) begin
            advance = 1'b1;
          end
        end
      end
      ST_HALTED: advance = RESUME_PCF;
      default:   advance = 1'b0;
    endcase
    cand       = use_br ? BR_TARGET_PCF : seq_sum[31:0];
    cand_legal = use_br ? br_legal      : seq_legal;
    cand_cause = use_br ? br_cause      : seq_cause;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      valid       <= 1'b0;
      trap_cause  <= CAUSE_NONE;
      trap_pc     <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          valid <= 1'b1;
        end
        ST_RUN, ST_HALTED: begin
          if (state == ST_RUN && HALT_PCF) begin
            state <= ST_HALTED;
            valid <= 1'b0;
          end else if (advance) begin
            if (cand_legal) begin
              pc    <= cand;
              state <= ST_RUN;
              valid <= 1'b1;
              // Resume from HALTED moves the PC but is not a RUN update.
              if (state == ST_RUN) retired_cnt <= retired_cnt + 32'd1;
            end else begin
              state      <= ST_TRAP;
              valid      <= 1'b0;
              trap_pc    <= cand;
              trap_cause <= trap_cause_t'(cand_cause);
            end
          end
        end
        default: ; // TRAP is sticky until reset
      endcase
    end
  end

  assign A_IM            = pc;
  assign PC_PLUS4_PCF    = pc + 32'd4;
  assign VALID_PCF       = valid;
  assign STATE_PCF       = state;
  assign TRAP_CAUSE_PCF  = trap_cause;
  assign TRAP_PC_PCF     = trap_pc;
  assign RETIRED_CNT_PCF = retired_cnt;

endmodule

// File: tb/tb_program_counter_fetch.sv
module tb_program_counter_fetch;

  localparam int unsigned IMEM = 256;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL_PCF;
  logic        BR_TAKEN_PCF;
  logic [31:0] BR_TARGET_PCF;
  logic        HALT_PCF;
  logic        RESUME_PCF;
  logic [31:0] A_IM;
  logic [31:0] PC_PLUS4_PCF;
  logic        VALID_PCF;
  logic [1:0]  STATE_PCF;
  logic [1:0]  TRAP_CAUSE_PCF;
  logic [31:0] TRAP_PC_PCF;
  logic [31:0] RETIRED_CNT_PCF;

  int errors = 0;
  int checks = 0;

  program_counter_fetch #(.RESET_VECTOR(32'h0), .IMEM_WORDS(IMEM)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .STALL_PCF       (STALL_PCF),
    .BR_TAKEN_PCF    (BR_TAKEN_PCF),
    .BR_TARGET_PCF   (BR_TARGET_PCF),
    .HALT_PCF        (HALT_PCF),
    .RESUME_PCF      (RESUME_PCF),
    .A_IM            (A_IM),
    .PC_PLUS4_PCF    (PC_PLUS4_PCF),
    .VALID_PCF       (VALID_PCF),
    .STATE_PCF       (STATE_PCF),
    .TRAP_CAUSE_PCF  (TRAP_CAUSE_PCF),
    .TRAP_PC_PCF     (TRAP_PC_PCF),
    .RETIRED_CNT_PCF (RETIRED_CNT_PCF)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: PC as a wide integer, legality from plain arithmetic.
  longint m_pc    = 0;
  int     m_state = 0; // 0 boot, 1 run, 2 halted, 3 trap
  bit     m_valid = 0;
  int     m_cause = 0;
  longint m_tpc   = 0;
  longint m_cnt   = 0;

  task model_try(input longint target, input bit counts);
    if (target % 4 != 0) begin
      m_state = 3; m_valid = 0; m_cause = 1; m_tpc = target % 64'h1_0000_0000;
    end else if (target >= IMEM * 4) begin
      m_state = 3; m_valid = 0; m_cause = 2; m_tpc = target % 64'h1_0000_0000;
    end else begin
      m_pc = target; m_state = 1; m_valid = 1;
      if (counts) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
    end
  endtask

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_pc = 0; m_state = 0; m_valid = 0; m_cause = 0; m_tpc = 0; m_cnt = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_valid = 1; end
        1: begin
          if (HALT_PCF) begin m_state = 2; m_valid = 0; end
          else if (BR_TAKEN_PCF) model_try(longint'(BR_TARGET_PCF), 1'b1);
          else if (!STALL_PCF) model_try(m_pc + 4, 1'b1);
        end
        2: if (RESUME_PCF) model_try(m_pc + 4, 1'b0);
        default: ;
      endcase
    end
  end

  task tick();
    @(posedge CLK);
    #1;
  endtask

  task idle_inputs();
    STALL_PCF = 0; BR_TAKEN_PCF = 0; BR_TARGET_PCF = '0; HALT_PCF = 0; RESUME_PCF = 0;
  endtask

  task reset_and_boot();
    idle_inputs();
    RST_N = 0; tick();
    RST_N = 1; tick();
  endtask

  task test_reset();
    idle_inputs();
    RST_N = 0; tick(); tick();
    checks++; if (A_IM !== 32'h0) begin errors++; $display("FAIL reset_a_im: got %h want %h", A_IM, 32'h0); end
    checks++; if (VALID_PCF !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID_PCF); end
    checks++; if (STATE_PCF !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", STATE_PCF); end
    checks++; if (TRAP_CAUSE_PCF !== 2'b00 || TRAP_PC_PCF !== 32'h0) begin errors++; $display("FAIL reset_trap: got %b/%h want 00/0", TRAP_CAUSE_PCF, TRAP_PC_PCF); end
    checks++; if (RETIRED_CNT_PCF !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", RETIRED_CNT_PCF); end
    RST_N = 1; tick();
    checks++; if (STATE_PCF !== 2'b01 || VALID_PCF !== 1'b1) begin errors++; $display("FAIL boot_to_run: got state %b valid %b want 01/1", STATE_PCF, VALID_PCF); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++; if (A_IM !== 32'(i * 4)) begin errors++; $display("FAIL seq_a_im[%0d]: got %h want %h", i, A_IM, 32'(i * 4)); end
      checks++; if (RETIRED_CNT_PCF !== 32'(i)) begin errors++; $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, RETIRED_CNT_PCF, i); end
    end
    checks++; if (PC_PLUS4_PCF !== 32'hC) begin errors++; $display("FAIL pc_plus4: got %h want c", PC_PLUS4_PCF); end
  endtask

  task test_stall();
    STALL_PCF = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (A_IM !== 32'h8 || RETIRED_CNT_PCF !== 32'd2) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%0d want 8/2", i, A_IM, RETIRED_CNT_PCF); end
    end
    STALL_PCF = 0; tick();
    checks++; if (A_IM !== 32'hC || RETIRED_CNT_PCF !== 32'd3) begin errors++; $display("FAIL stall_release: got %h/%0d want c/3", A_IM, RETIRED_CNT_PCF); end
  endtask

  task test_redirect_stall();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h40; STALL_PCF = 1; tick();
    idle_inputs();
    checks++; if (A_IM !== 32'h40 || RETIRED_CNT_PCF !== 32'd4) begin errors++; $display("FAIL redirect_stall: got %h/%0d want 40/4", A_IM, RETIRED_CNT_PCF); end
  endtask

  task test_misaligned();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h42; tick();
    checks++; if (STATE_PCF !== 2'b11 || TRAP_CAUSE_PCF !== 2'b01) begin errors++; $display("FAIL mis_trap: got %b/%b want 11/01", STATE_PCF, TRAP_CAUSE_PCF); end
    checks++; if (TRAP_PC_PCF !== 32'h42 || A_IM !== 32'h40 || VALID_PCF !== 1'b0) begin errors++; $display("FAIL mis_capture: got tpc %h pc %h v %b want 42/40/0", TRAP_PC_PCF, A_IM, VALID_PCF); end
    BR_TARGET_PCF = 32'h80; RESUME_PCF = 1; HALT_PCF = 1; tick(); tick();
    checks++; if (STATE_PCF !== 2'b11 || A_IM !== 32'h40 || TRAP_PC_PCF !== 32'h42 || TRAP_CAUSE_PCF !== 2'b01) begin errors++; $display("FAIL mis_sticky: got %b %h %h %b want 11 40 42 01", STATE_PCF, A_IM, TRAP_PC_PCF, TRAP_CAUSE_PCF); end
    RST_N = 0; tick();
    checks++; if (STATE_PCF !== 2'b00 || A_IM !== 32'h0 || TRAP_CAUSE_PCF !== 2'b00) begin errors++; $display("FAIL trap_reset: got %b %h %b want 00 0 00", STATE_PCF, A_IM, TRAP_CAUSE_PCF); end
    reset_and_boot();
  endtask

  task test_range();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h3FC; tick();
    checks++; if (A_IM !== 32'h3FC || STATE_PCF !== 2'b01) begin errors++; $display("FAIL range_last_legal: got %h/%b want 3fc/01", A_IM, STATE_PCF); end
    idle_inputs(); tick();
    checks++; if (STATE_PCF !== 2'b11 || TRAP_CAUSE_PCF !== 2'b10 || TRAP_PC_PCF !== 32'h400 || A_IM !== 32'h3FC) begin errors++; $display("FAIL range_seq: got %b %b %h %h want 11 10 400 3fc", STATE_PCF, TRAP_CAUSE_PCF, TRAP_PC_PCF, A_IM); end
    reset_and_boot();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h400; tick();
    checks++; if (STATE_PCF !== 2'b11 || TRAP_CAUSE_PCF !== 2'b10 || TRAP_PC_PCF !== 32'h400) begin errors++; $display("FAIL range_target: got %b %b %h want 11 10 400", STATE_PCF, TRAP_CAUSE_PCF, TRAP_PC_PCF); end
    reset_and_boot();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h402; tick();
    checks++; if (STATE_PCF !== 2'b11 || TRAP_CAUSE_PCF !== 2'b01 || TRAP_PC_PCF !== 32'h402) begin errors++; $display("FAIL range_mis_wins: got %b %b %h want 11 01 402", STATE_PCF, TRAP_CAUSE_PCF, TRAP_PC_PCF); end
    reset_and_boot();
  endtask

  task test_halt();
    BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h10; tick();
    idle_inputs(); HALT_PCF = 1; tick();
    checks++; if (STATE_PCF !== 2'b10 || VALID_PCF !== 1'b0 || A_IM !== 32'h10 || RETIRED_CNT_PCF !== 32'd1) begin errors++; $display("FAIL halt_enter: got %b %b %h %0d want 10 0 10 1", STATE_PCF, VALID_PCF, A_IM, RETIRED_CNT_PCF); end
    HALT_PCF = 0; BR_TAKEN_PCF = 1; BR_TARGET_PCF = 32'h80; tick();
    BR_TAKEN_PCF = 0; STALL_PCF = 1; HALT_PCF = 1; tick();
    checks++; if (STATE_PCF !== 2'b10 || A_IM !== 32'h10) begin errors++; $display("FAIL halt_ignore: got %b %h want 10 10", STATE_PCF, A_IM); end
    idle_inputs(); RESUME_PCF = 1; tick();
    RESUME_PCF = 0;
    checks++; if (STATE_PCF !== 2'b01 || A_IM !== 32'h14 || VALID_PCF !== 1'b1) begin errors++; $display("FAIL resume: got %b %h %b want 01 14 1", STATE_PCF, A_IM, VALID_PCF); end
    HALT_PCF = 1; RESUME_PCF = 1; tick();
    idle_inputs();
    checks++; if (STATE_PCF !== 2'b10 || A_IM !== 32'h14) begin errors++; $display("FAIL halt_resume_together: got %b %h want 10 14", STATE_PCF, A_IM); end
    RESUME_PCF = 1; tick();
    RESUME_PCF = 0;
    checks++; if (STATE_PCF !== 2'b01 || A_IM !== 32'h18) begin errors++; $display("FAIL resume2: got %b %h want 01 18", STATE_PCF, A_IM); end
  endtask

  task test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      RST_N        = ($urandom_range(0, 99) != 0);
      HALT_PCF     = ($urandom_range(0, 19) == 0);
      RESUME_PCF   = ($urandom_range(0, 3) == 0);
      STALL_PCF    = ($urandom_range(0, 3) == 0);
      BR_TAKEN_PCF = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      if (r < 7)       BR_TARGET_PCF = 32'($urandom_range(0, IMEM - 1)) << 2;
      else if (r == 7) BR_TARGET_PCF = ($urandom() & ~32'h3) | 32'h400;
      else             BR_TARGET_PCF = $urandom();
      tick();
      checks++; if (A_IM !== 32'(m_pc)) begin errors++; $display("FAIL rnd_a_im[%0d]: got %h want %h", i, A_IM, 32'(m_pc)); end
      checks++; if (PC_PLUS4_PCF !== 32'(m_pc + 4)) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h want %h", i, PC_PLUS4_PCF, 32'(m_pc + 4)); end
      checks++; if (VALID_PCF !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, VALID_PCF, m_valid); end
      checks++; if (STATE_PCF !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %b want %b", i, STATE_PCF, 2'(m_state)); end
      checks++; if (TRAP_CAUSE_PCF !== 2'(m_cause)) begin errors++; $display("FAIL rnd_cause[%0d]: got %b want %b", i, TRAP_CAUSE_PCF, 2'(m_cause)); end
      checks++; if (TRAP_PC_PCF !== 32'(m_tpc)) begin errors++; $display("FAIL rnd_trap_pc[%0d]: got %h want %h", i, TRAP_PC_PCF, 32'(m_tpc)); end
      checks++; if (RETIRED_CNT_PCF !== 32'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, RETIRED_CNT_PCF, 32'(m_cnt)); end
    end
  endtask

  initial begin
    RST_N = 0;
    idle_inputs();
    test_reset();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_range();
    test_halt();
    reset_and_boot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
